miner_ctrl: RTL and testbench
=============================

Name: miner_ctrl

Overview:
- Sequencer for one shared SHA-256 compression core, performing the Bitcoin double hash over a nonce range.
- Computes the block-1 midstate once per job.
- Per nonce, runs block 2 from the midstate, then a second hash of that digest from the IV.
- Compares each final digest against a target. Sits between the job/host interface and the compression core.

Parameters:
- CORE_TIMEOUT, 256: max cycles from core_start to core_done before error is raised.
- TW, 16: width of the timeout counter; CORE_TIMEOUT must be < 2^TW.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job launch pulse; sampled only in IDLE
- abort  in  1  cancel current job
- header_in  in  640  80-byte header. [639:128] = block 1; [127:32] = tail; [31:0] ignored.
- nonce_start  in  32  first nonce, inclusive
- nonce_end  in  32  last nonce, inclusive
- target  in  256  a hit is digest <= target
- core_start  out  1  one-cycle pulse; core latches core_block/core_hin
- core_block  out  512  message block for the core
- core_hin  out  256  chaining value {h0..h7}, h0 at MSBs
- core_done  in  1  one-cycle pulse; core_digest valid this cycle
- core_digest  in  256  core result, h0 at MSBs
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- found  out  1  sticky hit flag, cleared at next start
- error  out  1  sticky core-timeout flag, cleared at next start
- nonce_out  out  32  winning nonce, valid when found
- hash_out  out  256  winning second digest
- nonces_tried  out  32  count of completed second hashes in the current job

Behaviour:
- Reset: all outputs 0; state IDLE; internal regs (midstate, nonce, digest1, timer) 0.
- States: IDLE, MID_GO, MID_WAIT, H1_GO, H1_WAIT, H2_GO, H2_WAIT, CHECK, FIN.
- IDLE + start:
  - Latch header_in, nonce_start, nonce_end, target.
  - Clear found, error, nonces_tried.
  - busy=1.
  - If nonce_start > nonce_end, go to FIN (no core passes); otherwise go to MID_GO.
- *_GO states: assert core_start for exactly 1 cycle, clear timer, go to matching *_WAIT. core_block/core_hin stay stable from GO until core_done.
- MID pass:
  - block = header[639:128]; hin = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - On done, latch midstate; go to H1_GO.
- H1 pass:
  - block = {header[127:32], nonce, 32'h80000000, 288'b0, 64'd640}; hin = midstate.
  - Nonce is inserted without byte swap.
  - On done, latch digest1; go to H2_GO.
- H2 pass:
  - block = {digest1, 32'h80000000, 160'b0, 64'd256}; hin = IV.
  - On done, latch digest2, nonces_tried+1; go to CHECK.
- CHECK:
  - If digest2 <= target (unsigned 256-bit, h0 most significant): found=1, nonce_out=nonce, hash_out=digest2, go to FIN.
  - Else if nonce == nonce_end: go to FIN.
  - Else nonce+1, go to H1_GO. Midstate is reused; no MID pass.
- No wrap: nonce_end = 32'hFFFFFFFF terminates after that nonce; the nonce register is never incremented past nonce_end.
- FIN: done pulse for 1 cycle, busy=0, go to IDLE. found/nonce_out/hash_out/error hold until next start.
- Per-nonce cost: 2 core passes + 3 controller cycles (GO, GO, CHECK). Job cost: 1 midstate pass + that per nonce + FIN.
- Timeout:
  - Timer counts each cycle in a *_WAIT state.
  - At timer == CORE_TIMEOUT without core_done: error=1, go to FIN. found stays unchanged.
- Ignored inputs:
  - core_done outside *_WAIT.
  - start while busy.
- abort:
  - Any non-IDLE state goes to IDLE next cycle: busy=0, no done pulse, found/nonces_tried retain current values.
  - Abort in the same cycle as core_done: abort wins.
- Reset mid-job: returns to reset values immediately; core is not signalled.

Decomposition:
- Package sha256_pkg:
  - SHA-256 IV constant.
  - Padding constants (32'h80000000, lengths 640 and 256).
  - ctrl_state_t enum.
  - Shared with the compression core.
- Sub-module blk_fmt: purely combinational builder of core_block/core_hin from pass select, header, nonce, midstate, digest1. All sequencing stays in miner_ctrl.

Test Plan:
- Hit on first nonce: target=all-ones, range 5..9, BFM core (done 64 cycles later, digest = fixed pattern) -> 3 core_start pulses, found=1, nonce_out=5, nonces_tried=1, one done pulse.
- Full sweep, no hit: target=0, range 0..3 -> 9 core_start pulses, found=0, nonces_tried=4, done once, busy low after.
- No-wrap boundary: range FFFFFFFE..FFFFFFFF, target=0 -> nonces_tried=2, last H1 block nonce field FFFFFFFF. Separately, range 7..6 -> done 2 cycles after start, zero core_start pulses.
- Block format: nonce 0x12345678, BFM digest1 = 0x0011..FF pattern -> H1 block[415:384]=12345678, [63:0]=640; H2 block[255:224]=80000000, [63:0]=256, hin=IV.
- Timeout: CORE_TIMEOUT=8, BFM never asserts done -> error=1, done pulse 10 cycles after core_start, busy=0.
- Abort: abort asserted in H1_WAIT simultaneously with core_done -> IDLE next cycle, no done pulse, nonces_tried unchanged. New start afterwards runs normally.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants and controller types shared by miner_ctrl, blk_fmt and the compression core.
// Latency: n/a (package only).
// Backpressure: n/a.
package sha256_pkg;

  // Initial chaining value {h0..h7}, h0 at the MSBs.
  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Padding: a single 1 bit after the message, then the message length in bits.
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;
  localparam logic [63:0] LEN_BLK1 = 64'd640; // 80-byte header
  localparam logic [63:0] LEN_BLK2 = 64'd256; // 32-byte first digest

  typedef enum logic [3:0] {
    IDLE,
    MID_GO,
    MID_WAIT,
    H1_GO,
    H1_WAIT,
    H2_GO,
    H2_WAIT,
    CHECK,
    FIN
  } ctrl_state_t;

  // Which compression pass the core inputs are formatted for.
  typedef enum logic [1:0] {
    PASS_NONE,
    PASS_MID,
    PASS_H1,
    PASS_H2
  } pass_sel_t;

  function automatic pass_sel_t pass_of(input ctrl_state_t s);
    case (s)
      MID_GO, MID_WAIT: pass_of = PASS_MID;
      H1_GO, H1_WAIT:   pass_of = PASS_H1;
      H2_GO, H2_WAIT:   pass_of = PASS_H2;
      default:          pass_of = PASS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/miner_ctrl_blk_fmt.sv
// blk_fmt: builds the 512-bit message block and 256-bit chaining input for the selected pass.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: pass (pass select), hdr (header bits [639:32]), nonce, midstate, digest1 in;
//        block (core message block), hin (core chaining value) out. PASS_NONE drives zeros.
module blk_fmt
  import sha256_pkg::*;
(
  input  pass_sel_t      pass,
  input  logic [607:0]   hdr,
  input  logic [31:0]    nonce,
  input  logic [255:0]   midstate,
  input  logic [255:0]   digest1,
  output logic [511:0]   block,
  output logic [255:0]   hin
);

  always_comb begin
    block = '0;
    hin   = '0;
    case (pass)
      PASS_MID: begin
        block = hdr[607:96];
        hin   = SHA256_IV;
      end
      PASS_H1: begin
        // Header tail, nonce as-is (no byte swap), then padding for a 640-bit message.
        block = {hdr[95:0], nonce, PAD_WORD, 288'b0, LEN_BLK1};
        hin   = midstate;
      end
      PASS_H2: begin
        block = {digest1, PAD_WORD, 160'b0, LEN_BLK2};
        hin   = SHA256_IV;
      end
      default: begin
        block = '0;
        hin   = '0;
      end
    endcase
  end

endmodule

// File: rtl/miner_ctrl.sv
// miner_ctrl: sequences one shared SHA-256 core through midstate + per-nonce double hash, compares to target.
// Latency: 1 midstate pass, then per nonce 2 core passes + 3 cycles; FIN adds one; outputs registered.
// Backpressure: one core request outstanding at a time; waits on core_done, errors after CORE_TIMEOUT.
// Ports: clk, reset (sync, active-high); job side start/abort/header_in/nonce_start/nonce_end/target;
//        core side core_start/core_block/core_hin out, core_done/core_digest in;
//        status busy/done/found/error/nonce_out/hash_out/nonces_tried out.
module miner_ctrl
  import sha256_pkg::*;
#(
  parameter int CORE_TIMEOUT = 256,
  parameter int TW           = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [639:0] header_in,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic [255:0] target,
  output logic         core_start,
  output logic [511:0] core_block,
  output logic [255:0] core_hin,
  input  logic         core_done,
  input  logic [255:0] core_digest,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         error,
  output logic [31:0]  nonce_out,
  output logic [255:0] hash_out,
  output logic [31:0]  nonces_tried
);

  ctrl_state_t    state;
  logic [607:0]   hdr;        // header bits [639:32]; the low word is never hashed
  logic [31:0]    nonce;
  logic [31:0]    nonce_last;
  logic [255:0]   tgt;
  logic [255:0]   midstate;
  logic [255:0]   digest1;
  logic [255:0]   digest2;
  logic [TW-1:0]  timer;
  pass_sel_t      pass_sel;
  logic           timed_out;
  logic           hdr_unused;

  assign hdr_unused = ^header_in[31:0];
  assign timed_out  = (timer == TW'(CORE_TIMEOUT));
  assign pass_sel   = pass_of(state);

  // Block/hin depend only on registered state, so they stay stable from GO through core_done.
  blk_fmt u_blk_fmt (
    .pass     (pass_sel),
    .hdr      (hdr),
    .nonce    (nonce),
    .midstate (midstate),
    .digest1  (digest1),
    .block    (core_block),
    .hin      (core_hin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      hdr          <= '0;
      nonce        <= '0;
      nonce_last   <= '0;
      tgt          <= '0;
      midstate     <= '0;
      digest1      <= '0;
      digest2      <= '0;
      timer        <= '0;
      core_start   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      found        <= 1'b0;
      error        <= 1'b0;
      nonce_out    <= '0;
      hash_out     <= '0;
      nonces_tried <= '0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      if (abort && state != IDLE) begin
        // Abort beats everything, including a core_done in the same cycle.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              hdr          <= header_in[639:32];
              nonce        <= nonce_start;
              nonce_last   <= nonce_end;
              tgt          <= target;
              found        <= 1'b0;
              error        <= 1'b0;
              nonces_tried <= '0;
              busy         <= 1'b1;
              state        <= (nonce_start > nonce_end) ? FIN : MID_GO;
            end
          end
          MID_GO, H1_GO, H2_GO: begin
            core_start <= 1'b1;
            timer      <= '0;
            state      <= (state == MID_GO) ? MID_WAIT :
                          (state == H1_GO)  ? H1_WAIT  : H2_WAIT;
          end
          MID_WAIT, H1_WAIT, H2_WAIT: begin
            if (core_done) begin
              case (state)
                MID_WAIT: begin
                  midstate <= core_digest;
                  state    <= H1_GO;
                end
                H1_WAIT: begin
                  digest1 <= core_digest;
                  state   <= H2_GO;
                end
                default: begin
                  digest2      <= core_digest;
                  nonces_tried <= nonces_tried + 32'd1;
                  state        <= CHECK;
                end
              endcase
            end else if (timed_out) begin
              error <= 1'b1;
              state <= FIN;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          CHECK: begin
            if (digest2 <= tgt) begin
              found     <= 1'b1;
              nonce_out <= nonce;
              hash_out  <= digest2;
              state     <= FIN;
            end else if (nonce == nonce_last) begin
              // Stop here rather than incrementing, so 32'hFFFFFFFF never wraps.
              state <= FIN;
            end else begin
              nonce <= nonce + 32'd1;
              state <= H1_GO;
            end
          end
          FIN: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_miner_ctrl.sv
// Bench for miner_ctrl: table of jobs against a fixed-latency core model, plus abort/reset/timeout sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_miner_ctrl;
  import sha256_pkg::*;

  localparam int LAT = 64;
  localparam logic [255:0] PAT =
    256'h00112233445566778899AABBCCDDEEFF00112233445566778899AABBCCDDEEFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, abort;
  logic [639:0] header_in;
  logic [31:0]  nonce_start, nonce_end;
  logic [255:0] target;
  logic         core_start, core_done;
  logic [511:0] core_block;
  logic [255:0] core_hin, core_digest;
  logic         busy, done, found, error;
  logic [31:0]  nonce_out, nonces_tried;
  logic [255:0] hash_out;

  // Second instance with a short timeout and a core that never answers.
  logic         start2, abort2, core_done2;
  logic [255:0] core_digest2;
  logic         core_start2, busy2, done2, found2, error2;
  logic [511:0] core_block2;
  logic [255:0] core_hin2, hash_out2;
  logic [31:0]  nonce_out2, tried2;

  miner_ctrl #(.CORE_TIMEOUT(256), .TW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .header_in(header_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_start(core_start), .core_block(core_block), .core_hin(core_hin),
    .core_done(core_done), .core_digest(core_digest), .busy(busy), .done(done),
    .found(found), .error(error), .nonce_out(nonce_out), .hash_out(hash_out),
    .nonces_tried(nonces_tried)
  );

  miner_ctrl #(.CORE_TIMEOUT(8), .TW(16)) dut_to (
    .clk(clk), .reset(reset), .start(start2), .abort(abort2), .header_in(header_in),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target),
    .core_start(core_start2), .core_block(core_block2), .core_hin(core_hin2),
    .core_done(core_done2), .core_digest(core_digest2), .busy(busy2), .done(done2),
    .found(found2), .error(error2), .nonce_out(nonce_out2), .hash_out(hash_out2),
    .nonces_tried(tried2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Core model: answers each request LAT cycles later with digest = base - request index.
  logic [255:0] base;
  logic [511:0] blk_q [16];
  logic [255:0] hin_q [16];
  int start_cnt, done_cnt, abort_idx, cur_idx, cnt;

  initial begin : core_bfm
    core_done = 1'b0; core_digest = '0; abort = 1'b0; cnt = 0; cur_idx = 0;
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      abort     = 1'b0;
      if (done) done_cnt++;
      if (core_start) begin
        if (start_cnt < 16) begin
          blk_q[start_cnt] = core_block;
          hin_q[start_cnt] = core_hin;
        end
        cur_idx = start_cnt;
        start_cnt++;
        cnt = LAT;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done   = 1'b1;
          core_digest = base - 256'(cur_idx);
          if (cur_idx == abort_idx) abort = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic [31:0]  ns;
    logic [31:0]  ne;
    logic [255:0] tgt;
    logic         exp_found;
    logic [31:0]  exp_nonce;
    logic [255:0] exp_hash;
    int           tried;
    int           starts;
    logic [31:0]  last_nonce;
  } vec_t;

  vec_t tbl [7];

  task automatic run_job(input vec_t v, input string tag);
    int  cyc;
    bit  seen;
    start_cnt = 0;
    done_cnt  = 0;
    nonce_start = v.ns;
    nonce_end   = v.ne;
    target      = v.tgt;
    start = 1'b1;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk({tag, " busy_after_start"}, busy, 1);
      end
      if (done) seen = 1;
    end
    chk({tag, " done_seen"}, seen, 1);
    if (v.starts == 0) chk({tag, " empty_range_latency"}, cyc, 2);
    chk({tag, " busy_at_done"}, busy, 0);
    repeat (4) @(negedge clk);
    chk({tag, " found"}, found, v.exp_found);
    chk({tag, " nonces_tried"}, nonces_tried, v.tried);
    chk({tag, " core_starts"}, start_cnt, v.starts);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " error"}, error, 0);
    if (v.exp_found) begin
      chk({tag, " nonce_out"}, nonce_out, v.exp_nonce);
      chk({tag, " hash_out"}, hash_out, v.exp_hash);
    end
    if (v.starts >= 2) chk({tag, " last_h1_nonce"}, blk_q[v.starts-2][415:384], v.last_nonce);
  endtask

  initial begin : main
    vec_t bf;
    int   c;
    bit   seen;
    reset = 1'b1; start = 1'b0; start2 = 1'b0; abort2 = 1'b0;
    core_done2 = 1'b0; core_digest2 = '0;
    nonce_start = '0; nonce_end = '0; target = '0;
    start_cnt = 0; done_cnt = 0; abort_idx = -1;
    base = PAT + 256'd1;
    for (int i = 0; i < 20; i++) header_in[i*32 +: 32] = 32'hA500_0000 + 32'(i * 7);

    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst found", found, 0);
    chk("rst error", error, 0);
    chk("rst nonce_out", nonce_out, 0);
    chk("rst hash_out", hash_out, 0);
    chk("rst nonces_tried", nonces_tried, 0);
    chk("rst core_start", core_start, 0);
    chk("rst core_block", core_block[255:0] | core_block[511:256], 0);
    chk("rst core_hin", core_hin, 0);
    reset = 1'b0;
    @(negedge clk);

    tbl[0] = '{32'd5, 32'd9, '1, 1'b1, 32'd5, base - 256'd2, 1, 3, 32'd5};
    tbl[1] = '{32'd0, 32'd3, '0, 1'b0, 32'd0, '0, 4, 9, 32'd3};
    tbl[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, '0, 1'b0, 32'd0, '0, 2, 5, 32'hFFFF_FFFF};
    tbl[3] = '{32'd7, 32'd6, '0, 1'b0, 32'd0, '0, 0, 0, 32'd0};
    tbl[4] = '{32'd10, 32'd12, base - 256'd4, 1'b1, 32'd11, base - 256'd4, 2, 5, 32'd11};
    tbl[5] = '{32'd10, 32'd12, base - 256'd5, 1'b1, 32'd12, base - 256'd6, 3, 7, 32'd12};
    tbl[6] = '{32'd10, 32'd12, base - 256'd7, 1'b0, 32'd0, '0, 3, 7, 32'd12};
    for (int i = 0; i < 7; i++) run_job(tbl[i], $sformatf("vec%0d", i));

    // Block format for a single nonce.
    bf = '{32'h1234_5678, 32'h1234_5678, '0, 1'b0, 32'd0, '0, 1, 3, 32'h1234_5678};
    run_job(bf, "fmt");
    chk("fmt mid_block", blk_q[0], header_in[639:128]);
    chk("fmt mid_hin", hin_q[0], SHA256_IV);
    chk("fmt h1_tail", blk_q[1][511:416], header_in[127:32]);
    chk("fmt h1_nonce", blk_q[1][415:384], 32'h1234_5678);
    chk("fmt h1_pad", blk_q[1][383:352], 32'h8000_0000);
    chk("fmt h1_zero", blk_q[1][351:64], 0);
    chk("fmt h1_len", blk_q[1][63:0], 640);
    chk("fmt h1_hin", hin_q[1], base);
    chk("fmt h2_digest1", blk_q[2][511:256], PAT);
    chk("fmt h2_pad", blk_q[2][255:224], 32'h8000_0000);
    chk("fmt h2_zero", blk_q[2][223:64], 0);
    chk("fmt h2_len", blk_q[2][63:0], 256);
    chk("fmt h2_hin", hin_q[2], SHA256_IV);

    // Abort together with core_done of the second H1 pass.
    abort_idx = 3; start_cnt = 0; done_cnt = 0;
    nonce_start = 32'd20; nonce_end = 32'd25; target = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0; c = 0;
    while (!seen && c < 2000) begin
      @(negedge clk);
      c++;
      if (abort) seen = 1;
    end
    chk("abort seen", seen, 1);
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort nonces_tried", nonces_tried, 1);
    chk("abort found", found, 0);
    repeat (150) @(negedge clk);
    chk("abort done_pulses", done_cnt, 0);
    chk("abort core_starts", start_cnt, 4);
    abort_idx = -1;
    run_job(tbl[0], "after_abort");

    // Reset in the middle of a job.
    start_cnt = 0; done_cnt = 0;
    nonce_start = 32'd1; nonce_end = 32'd4; target = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst nonces_tried", nonces_tried, 0);
    repeat (100) @(negedge clk);
    chk("midrst core_starts", start_cnt, 1);
    chk("midrst done_pulses", done_cnt, 0);

    // Timeout on the short-timeout instance.
    nonce_start = 32'd0; nonce_end = 32'd3; target = '1;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    seen = 0; c = 0;
    while (!seen && c < 100) begin
      if (core_start2) seen = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk("to core_start", seen, 1);
    seen = 0; c = 0;
    while (!seen && c < 100) begin
      @(negedge clk);
      c++;
      if (done2) seen = 1;
    end
    chk("to done_seen", seen, 1);
    chk("to latency", c, 10);
    chk("to error", error2, 1);
    chk("to busy", busy2, 0);
    chk("to found", found2, 0);
    chk("to nonces_tried", tried2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
